pipe_add64: RTL and testbench

- Two-stage pipelined 64-bit adder with valid/ready handshakes on both sides.
- Stage 1 adds the low 32-bit halves plus carry-in and registers the low sum and carry-out.
- Stage 2 adds the high halves using the registered carry.
- Sits directly downstream of the 32-bit carry-lookahead adder: it consumes that adder's sum and Cout, and chains two instances into a wide, timing-closed datapath for FPGA fmax evaluation.

---
 rtl/pipe_add_pkg.sv | 27 ++
 rtl/pipe_add64_cla32.sv | 52 +++++
 rtl/pipe_add64.sv | 147 ++++++++++++++
 tb/tb_pipe_add64.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_add_pkg.sv
// Shared types for the two-stage 64-bit pipelined adder.
// The optional subtract mode is enabled by the macro PIPE_ADD64_SUB_EN.
package pipe_add_pkg;

    localparam int unsigned HALF_W = 32;
    localparam int unsigned WIDE_W = 64;

    typedef logic [HALF_W-1:0] half_t;

    // Stage-1 payload: finished low half plus the raw high operands.
    typedef struct packed {
        half_t lo_sum;
        logic  c32;
        half_t hi_a;
        half_t hi_b;
`ifdef PIPE_ADD64_SUB_EN
        logic  sub;
`endif
    } stage1_t;

    // Signed overflow: carry into the MSB (recovered from the MSB sum bit) xor carry out.
    function automatic logic msb_ovf(input logic a_msb, input logic b_msb,
                                     input logic s_msb, input logic c_out);
        return (a_msb ^ b_msb ^ s_msb) ^ c_out;
    endfunction

endpackage

// File: rtl/pipe_add64_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group G/P.
module pipe_add64_cla32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [7:0]  w_gg;
    logic [7:0]  w_gp;
    logic [32:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Group generate/propagate for each 4-bit slice.
    always_comb begin
        w_gg = '0;
        w_gp = '0;
        for (int k = 0; k < 8; k++) begin
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            w_gp[k] = w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k];
        end
    end

    // Bit carries inside each group, group carries from the G/P chain.
    always_comb begin
        w_c    = '0;
        w_c[0] = i_cin;
        for (int k = 0; k < 8; k++) begin
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
            w_c[4*k+2] = w_g[4*k+1]
                       | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+3] = w_g[4*k+2]
                       | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+4] = w_gg[k] | (w_gp[k] & w_c[4*k]);
        end
    end

    assign o_sum  = w_p ^ w_c[31:0];
    assign o_cout = w_c[32];

endmodule

// File: rtl/pipe_add64.sv
// Two-stage pipelined 64-bit adder with valid/ready on both sides.
// Stage 1 adds the low halves, stage 2 the high halves using the registered carry.
// in_ready is combinational from out_ready (full-throughput skid-free pipeline).
// Optional macro PIPE_ADD64_SUB_EN adds a 'sub' input selecting A-B (A+~B+1).
module pipe_add64
    import pipe_add_pkg::*;
#(
    parameter int unsigned HALF  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PIPE_ADD64_SUB_EN
    input  logic              sub,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              cin,
    input  logic [63:0]       op_a,
    input  logic [63:0]       op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       sum,
    output logic              cout,
    output logic              ovf,
    output logic [CNT_W-1:0]  done_cnt
);

    if (HALF != HALF_W) begin : g_bad_half
        $error("pipe_add64: HALF must be 32 to match the 32-bit adder");
    end

    logic              r_s1_valid;
    stage1_t           r_s1;
    logic              r_out_valid;
    logic [WIDE_W-1:0] r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_done_cnt;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_in_xfer;
    logic              w_out_xfer;
    half_t             w_lo_b;
    logic              w_cin;
    half_t             w_lo_sum;
    logic              w_c32;
    stage1_t           w_s1_next;
    half_t             w_hi_b;
    half_t             w_hi_sum;
    logic              w_c64;
    logic              w_ovf;

    assign w_s2_adv   = ~r_out_valid | out_ready;
    assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
    assign w_in_xfer  = in_valid & w_s1_adv;
    assign w_out_xfer = r_out_valid & out_ready;

`ifdef PIPE_ADD64_SUB_EN
    assign w_lo_b = sub ? ~op_b[HALF_W-1:0] : op_b[HALF_W-1:0];
    assign w_cin  = sub | cin;
    assign w_hi_b = r_s1.sub ? ~r_s1.hi_b : r_s1.hi_b;
`else
    assign w_lo_b = op_b[HALF_W-1:0];
    assign w_cin  = cin;
    assign w_hi_b = r_s1.hi_b;
`endif

    pipe_add64_cla32 u_cla_lo (
        .i_a    (op_a[HALF_W-1:0]),
        .i_b    (w_lo_b),
        .i_cin  (w_cin),
        .o_sum  (w_lo_sum),
        .o_cout (w_c32)
    );

    // Assemble the stage-1 payload from the low-half add and the raw high operands.
    always_comb begin
        w_s1_next        = '0;
        w_s1_next.lo_sum = w_lo_sum;
        w_s1_next.c32    = w_c32;
        w_s1_next.hi_a   = op_a[WIDE_W-1:HALF_W];
        w_s1_next.hi_b   = op_b[WIDE_W-1:HALF_W];
`ifdef PIPE_ADD64_SUB_EN
        w_s1_next.sub    = sub;
`endif
    end

    pipe_add64_cla32 u_cla_hi (
        .i_a    (r_s1.hi_a),
        .i_b    (w_hi_b),
        .i_cin  (r_s1.c32),
        .o_sum  (w_hi_sum),
        .o_cout (w_c64)
    );

    assign w_ovf = msb_ovf(r_s1.hi_a[HALF_W-1], w_hi_b[HALF_W-1],
                           w_hi_sum[HALF_W-1], w_c64);

    // Stage 1: capture on input transfer, empty when its content moves on unreplaced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (w_in_xfer) begin
                r_s1 <= w_s1_next;
            end
        end
    end

    // Stage 2: finish the high half; reloads in the same edge as an output transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= {w_hi_sum, r_s1.lo_sum};
                r_cout <= w_c64;
                r_ovf  <= w_ovf;
            end
        end
    end

    // Completed-transaction counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_cnt <= '0;
        end else if (w_out_xfer) begin
            r_done_cnt <= r_done_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_pipe_add64.sv
// Directed testbench for pipe_add64; inputs driven and outputs sampled on the falling edge.
module tb_pipe_add64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        cin;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic [31:0] done_cnt;
`ifdef PIPE_ADD64_SUB_EN
    logic        sub;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_add64 dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PIPE_ADD64_SUB_EN
        .sub       (sub),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cin       (cin),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .done_cnt  (done_cnt)
    );

    // Source must hold valid and operands stable while stalled.
    logic         p_wait = 1'b0;
    logic [128:0] p_snap;
    always @(posedge clk) begin
        if (!rst && p_wait) begin
            assert (in_valid && ({op_a, op_b, cin} === p_snap))
                else $error("protocol: input changed while stalled");
        end
        p_wait <= !rst && in_valid && !in_ready;
        p_snap <= {op_a, op_b, cin};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cin       = 1'b0;
        op_a      = '0;
        op_b      = '0;
`ifdef PIPE_ADD64_SUB_EN
        sub       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (sum !== 64'h0) $display("FAIL rst_sum: got %h want 0", sum); else n_pass++;
        n_total++; if (cout !== 1'b0) $display("FAIL rst_cout: got %b want 0", cout); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf); else n_pass++;
        n_total++; if (done_cnt !== 32'd0) $display("FAIL rst_done_cnt: got %0d want 0", done_cnt); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_directed;
        logic [63:0] va [3];
        logic [63:0] vb [3];
        logic [63:0] es [3];
        logic        vc [3];
        logic        ec [3];
        logic        eo [3];
        va[0] = 64'h0000_0000_FFFF_FFFF; vb[0] = 64'h1; vc[0] = 1'b0;
        es[0] = 64'h0000_0001_0000_0000; ec[0] = 1'b0; eo[0] = 1'b0;
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'hFFFF_FFFF_FFFF_FFFF; vc[1] = 1'b1;
        es[1] = 64'hFFFF_FFFF_FFFF_FFFF; ec[1] = 1'b1; eo[1] = 1'b0;
        va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'h1; vc[2] = 1'b0;
        es[2] = 64'h8000_0000_0000_0000; ec[2] = 1'b0; eo[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op_a = va[i]; op_b = vb[i]; cin = vc[i];
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            n_total++; if (out_valid !== 1'b0) $display("FAIL dir%0d_latency: out_valid %b after 1 cycle, want 0", i, out_valid); else n_pass++;
            @(negedge clk);
            n_total++;
            if ({out_valid, cout, ovf, sum} !== {1'b1, ec[i], eo[i], es[i]})
                $display("FAIL dir%0d_result: got v=%b c=%b o=%b s=%h want v=1 c=%b o=%b s=%h",
                         i, out_valid, cout, ovf, sum, ec[i], eo[i], es[i]);
            else n_pass++;
        end
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL dir_drain: out_valid %b want 0", out_valid); else n_pass++;
        n_total++; if (done_cnt !== 32'd3) $display("FAIL dir_done_cnt: got %0d want 3", done_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [63:0] va [10];
        logic [63:0] vb [10];
        logic [63:0] es [10];
        logic        vc [10];
        logic        ec [10];
        logic        eo [10];
        logic [64:0] t;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            va[i] = 64'h0123_4567_89AB_CDEF * 64'(i + 1);
            vb[i] = {va[i][31:0], va[i][63:32]} ^ 64'hF0F0_0F0F_FFFF_0000;
            vc[i] = 1'(i % 2);
            t     = {1'b0, va[i]} + {1'b0, vb[i]} + 65'(vc[i]);
            es[i] = t[63:0];
            ec[i] = t[64];
            eo[i] = (va[i][63] == vb[i][63]) && (t[63] != va[i][63]);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                n_total++;
                if ({out_valid, cout, ovf, sum} !== {1'b1, ec[c-2], eo[c-2], es[c-2]})
                    $display("FAIL b2b%0d: got v=%b c=%b o=%b s=%h want v=1 c=%b o=%b s=%h",
                             c - 2, out_valid, cout, ovf, sum, ec[c-2], eo[c-2], es[c-2]);
                else n_pass++;
            end
            out_ready = 1'b1;
            if (c < 10) begin
                in_valid = 1'b1; op_a = va[c]; op_b = vb[c]; cin = vc[c];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: out_valid %b want 0", out_valid); else n_pass++;
        n_total++; if (done_cnt !== 32'd10) $display("FAIL b2b_done_cnt: got %0d want 10", done_cnt); else n_pass++;
    endtask

    task automatic test_stall;
        logic [63:0] va [6];
        logic [63:0] vb [6];
        logic [63:0] es [6];
        logic        vc [6];
        logic        ec [6];
        logic        eo [6];
        logic [64:0] t;
        int          idx_in;
        int          idx_out;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            va[i] = {32'(i + 1) * 32'h1111_1111, 32'hFFFF_FFFF - 32'(i)};
            vb[i] = {32'h8000_0000, 32'(i + 1)};
            vc[i] = 1'(i % 2);
            t     = {1'b0, va[i]} + {1'b0, vb[i]} + 65'(vc[i]);
            es[i] = t[63:0];
            ec[i] = t[64];
            eo[i] = (va[i][63] == vb[i][63]) && (t[63] != va[i][63]);
        end
        idx_in  = 0;
        idx_out = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            in_valid  = (idx_in < 6);
            if (idx_in < 6) begin
                op_a = va[idx_in]; op_b = vb[idx_in]; cin = vc[idx_in];
            end
            #1;
            if (c >= 2 && c < 5) begin
                n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready c%0d: got %b want 0", c, in_ready); else n_pass++;
            end
            if (out_valid) begin
                n_total++;
                if (idx_out >= 6)
                    $display("FAIL stall_extra c%0d: unexpected output s=%h", c, sum);
                else if ({cout, ovf, sum} !== {ec[idx_out], eo[idx_out], es[idx_out]})
                    $display("FAIL stall_out%0d c%0d: got c=%b o=%b s=%h want c=%b o=%b s=%h",
                             idx_out, c, cout, ovf, sum, ec[idx_out], eo[idx_out], es[idx_out]);
                else n_pass++;
                if (out_ready) idx_out++;
            end
            if (in_valid && in_ready) idx_in++;
        end
        n_total++; if (idx_out !== 6) $display("FAIL stall_count: got %0d outputs want 6", idx_out); else n_pass++;
        n_total++; if (done_cnt !== 32'd6) $display("FAIL stall_done_cnt: got %0d want 6", done_cnt); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL stall_drain: out_valid %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; cin = 1'b0;
        op_a = 64'h10; op_b = 64'h20;
        @(negedge clk);
        op_a = 64'h30; op_b = 64'h40;
        @(negedge clk);
        op_a = 64'h50; op_b = 64'h60;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_total++;
        if ({out_valid, done_cnt} !== {1'b1, 32'd1})
            $display("FAIL mid_prefill: got v=%b cnt=%0d want v=1 cnt=1", out_valid, done_cnt);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (done_cnt !== 32'd0) $display("FAIL mid_done_cnt: got %0d want 0", done_cnt); else n_pass++;
        n_total++; if (sum !== 64'h0) $display("FAIL mid_sum: got %h want 0", sum); else n_pass++;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_total++; if (out_valid !== 1'b0) $display("FAIL mid_flush c%0d: out_valid %b want 0", c, out_valid); else n_pass++;
        end
        n_total++; if (done_cnt !== 32'd0) $display("FAIL mid_done_after: got %0d want 0", done_cnt); else n_pass++;
    endtask

`ifdef PIPE_ADD64_SUB_EN
    task automatic test_sub;
        logic [63:0] va [3];
        logic [63:0] vb [3];
        logic [63:0] es [3];
        logic        ec [3];
        logic        eo [3];
        va[0] = 64'h5; vb[0] = 64'h7;
        es[0] = 64'hFFFF_FFFF_FFFF_FFFE; ec[0] = 1'b0; eo[0] = 1'b0;
        va[1] = 64'h7; vb[1] = 64'h5;
        es[1] = 64'h2; ec[1] = 1'b1; eo[1] = 1'b0;
        va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h1;
        es[2] = 64'h7FFF_FFFF_FFFF_FFFF; ec[2] = 1'b1; eo[2] = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op_a = va[i]; op_b = vb[i]; cin = 1'b0; sub = 1'b1;
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            n_total++;
            if ({out_valid, cout, ovf, sum} !== {1'b1, ec[i], eo[i], es[i]})
                $display("FAIL sub%0d: got v=%b c=%b o=%b s=%h want v=1 c=%b o=%b s=%h",
                         i, out_valid, cout, ovf, sum, ec[i], eo[i], es[i]);
            else n_pass++;
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cin       = 1'b0;
        op_a      = '0;
        op_b      = '0;
`ifdef PIPE_ADD64_SUB_EN
        sub       = 1'b0;
`endif
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef PIPE_ADD64_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
